// File: rtl/perm_round_ctrl.sv
// Round controller for an Ascon-style permutation: sequences p12/p6 (and p8 when
// ASCON_P8_ROUNDS_EN is defined) through IDLE -> RUN -> DONE.
module perm_round_ctrl (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [1:0] mode_i,
  output logic [3:0] round_o,
  output logic       sel_init_o,
  output logic       en_state_o,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'd11;

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic [1:0] mode_q, mode_next;

  // Rounds always end at index 11, so a shorter permutation simply starts later.
  function automatic logic [3:0] first_idx(input logic [1:0] m);
    case (m)
      2'b00:   first_idx = 4'd0;
      2'b01:   first_idx = 4'd6;
`ifdef ASCON_P8_ROUNDS_EN
      2'b10:   first_idx = 4'd4;
`endif
      default: first_idx = 4'd0;
    endcase
  endfunction

  function automatic logic valid_mode(input logic [1:0] m);
    case (m)
      2'b00, 2'b01: valid_mode = 1'b1;
`ifdef ASCON_P8_ROUNDS_EN
      2'b10:        valid_mode = 1'b1;
`endif
      default:      valid_mode = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      mode_q <= 2'b00;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      mode_q <= mode_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    mode_next  = mode_q;
    round_o    = 4'd0;
    sel_init_o = 1'b0;
    en_state_o = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    case (state)
      IDLE: begin
        if (start_i && valid_mode(mode_i)) begin
          state_next = RUN;
          cnt_next   = first_idx(mode_i);
          mode_next  = mode_i;
        end
      end
      RUN: begin
        busy_o     = 1'b1;
        en_state_o = 1'b1;
        round_o    = cnt;
        // The latched mode identifies the first round, so mode_i may change freely.
        sel_init_o = (cnt == first_idx(mode_q));
        if (cnt == LAST_ROUND) begin
          state_next = DONE;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      DONE: begin
        busy_o     = 1'b1;
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_perm_round_ctrl.sv
// Directed bench for perm_round_ctrl; p8 expectations follow ASCON_P8_ROUNDS_EN.
module tb_perm_round_ctrl;

  logic       clk = 1'b0;
  logic       reset_i, start_i;
  logic [1:0] mode_i;
  logic [3:0] round_o;
  logic       sel_init_o, en_state_o, busy_o, done_o;
  logic [7:0] outs;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] exp_q[$];

  perm_round_ctrl dut (
    .clock_i    (clk),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .mode_i     (mode_i),
    .round_o    (round_o),
    .sel_init_o (sel_init_o),
    .en_state_o (en_state_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  assign outs = {busy_o, done_o, en_state_o, sel_init_o, round_o};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] mk(input logic b, input logic d, input logic e,
                                    input logic s, input logic [3:0] r);
    mk = {b, d, e, s, r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Launch one permutation and check every cycle; optionally poke start/mode at one RUN cycle.
  task automatic run_seq(input logic [1:0] m, input int n, input int first, input int poke);
    logic [3:0] er;
    mode_i  = m;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < n; k++) exp_q.push_back(4'(first + k));
    for (int i = 0; i < n; i++) begin
      er = exp_q.pop_front();
      check("run", 32'(outs), 32'(mk(1'b1, 1'b0, 1'b1, (i == 0), er)));
      if (i == poke) begin
        start_i = 1'b1;
        mode_i  = ~m;
      end else begin
        start_i = 1'b0;
      end
      tick();
    end
    start_i = 1'b0;
    mode_i  = m;
    check("done", 32'(outs), 32'(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd0)));
    tick();
    check("idle_after", 32'(outs), 32'h0);
    tick();
    check("idle_after2", 32'(outs), 32'h0);
  endtask

  int pulse_t[4];
  int npulse;

  initial begin
    reset_i = 1'b1;
    start_i = 1'b0;
    mode_i  = 2'b00;
    tick();
    tick();
    check("reset_outs", 32'(outs), 32'h0);

    // Reset wins over a simultaneous start.
    start_i = 1'b1;
    mode_i  = 2'b01;
    tick();
    check("reset_prio", 32'(outs), 32'h0);
    reset_i = 1'b0;
    start_i = 1'b0;
    tick();
    check("reset_prio_idle", 32'(outs), 32'h0);

    run_seq(2'b00, 12, 0, -1);
    run_seq(2'b01, 6, 6, -1);

`ifdef ASCON_P8_ROUNDS_EN
    run_seq(2'b10, 8, 4, -1);
`else
    mode_i  = 2'b10;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("p8_off_idle", 32'(outs), 32'h0);
      tick();
    end
`endif

    mode_i  = 2'b11;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("reserved_idle", 32'(outs), 32'h0);
      tick();
    end

    // Start and mode change at round 3 must not disturb p12.
    run_seq(2'b00, 12, 0, 3);

    // Abort at round 5.
    mode_i  = 2'b00;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("pre_abort", 32'(outs), 32'(mk(1'b1, 1'b0, 1'b1, (i == 0), 4'(i))));
      tick();
    end
    check("round5", 32'(outs), 32'(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd5)));
    reset_i = 1'b1;
    tick();
    check("abort", 32'(outs), 32'h0);
    reset_i = 1'b0;
    tick();
    check("abort_no_done", 32'(outs), 32'h0);
    run_seq(2'b00, 12, 0, -1);

    // Back-to-back p6 with start held high.
    npulse  = 0;
    mode_i  = 2'b01;
    start_i = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (done_o === 1'b1) begin
        if (npulse < 4) pulse_t[npulse] = c;
        npulse++;
      end
    end
    start_i = 1'b0;
    check("b2b_count", 32'(npulse), 32'd3);
    if (npulse >= 3) begin
      check("b2b_first", 32'(pulse_t[0]), 32'd6);
      check("b2b_gap1", 32'(pulse_t[1] - pulse_t[0]), 32'd8);
      check("b2b_gap2", 32'(pulse_t[2] - pulse_t[1]), 32'd8);
    end
    repeat (12) tick();
    check("b2b_drain_idle", 32'(outs), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/perm_round_ctrl.md
PERM_ROUND_CTRL -- requirements
Module: perm_round_ctrl

Interface
REQ-001 The block SHALL have no parameters; round index width SHALL be fixed at 4 bits.
REQ-002 clock_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_i  in  1  synchronous, active-high reset.
REQ-004 start_i  in  1  request one permutation; sampled only in IDLE.
REQ-005 mode_i  in  2  permutation select: 00 = p12, 01 = p6, 10 = p8 (macro-dependent), 11 = reserved.
REQ-006 round_o  out  4  round index driven to the constant-addition stage Round_i.
REQ-007 sel_init_o  out  1  1 = state register loads the external state, 0 = loads permutation feedback.
REQ-008 en_state_o  out  1  state register write enable.
REQ-009 busy_o  out  1  high in RUN and DONE.
REQ-010 done_o  out  1  one-cycle pulse when the permuted state is valid in the register.

Function
REQ-011 The FSM SHALL have states IDLE, RUN and DONE, encoded in one registered state variable.
REQ-012 IDLE -> RUN SHALL occur on a clock edge with start_i=1 and a valid mode_i; mode_i SHALL be latched on that same edge.
REQ-013 A start_i with a reserved mode_i SHALL be ignored: the FSM stays in IDLE and all outputs keep their IDLE values.
REQ-014 The first round index SHALL be 12-N, where N is 12, 6 or 8 for p12, p6 or p8, giving first indices 0, 6 and 4.
REQ-015 In RUN, round_o SHALL equal the registered counter; the counter SHALL increment by 1 each cycle, and round_o SHALL read 0 in IDLE and DONE.
REQ-016 en_state_o SHALL be 1 in every RUN cycle and 0 in every other state.
REQ-017 sel_init_o SHALL be 1 only in the first RUN cycle.
REQ-018 RUN -> DONE SHALL occur on the edge where the counter equals 11; the counter SHALL NOT wrap to 12 or beyond.
REQ-019 DONE SHALL last exactly one cycle with done_o=1, then return to IDLE unconditionally.
REQ-020 Latency: start accepted at edge E; RUN SHALL span cycles E+1 to E+N; done_o SHALL be high in cycle E+N+1; a new start SHALL be accepted no earlier than cycle E+N+2.
REQ-021 start_i SHALL be ignored in RUN and DONE, with no queuing and no effect on the counter or the latched mode.
REQ-022 A change of mode_i during RUN SHALL NOT affect the operation in progress.

Reset
REQ-023 While reset_i=1 at an edge, the next state SHALL be IDLE, the counter 0, the latched mode 00, and every output 0.
REQ-024 Reset asserted mid-operation SHALL abort the operation at the next edge, with no done_o pulse.
REQ-025 Reset SHALL take priority over a simultaneous start_i.

Configuration
REQ-026 The macro ASCON_P8_ROUNDS_EN SHALL control whether the 8-round permutation is compiled in.
REQ-027 With ASCON_P8_ROUNDS_EN defined, mode_i=10 SHALL select p8: first index 4, 8 RUN cycles.
REQ-028 Without ASCON_P8_ROUNDS_EN, mode_i=10 SHALL be treated as reserved (REQ-013), and no p8 logic SHALL remain in the design.

Verification
REQ-029 Reset, then start_i=1 with mode 00 -> round_o 0,1,...,11 over 12 RUN cycles; sel_init_o high only in cycle 1; done_o high at cycle 13; back in IDLE at cycle 14.
REQ-030 Start with mode 01 -> round_o 6,...,11; en_state_o high for exactly 6 cycles; done_o high at cycle 7.
REQ-031 Start with mode 10 and the macro defined -> round_o 4,...,11 and done_o at cycle 9; macro undefined -> busy_o stays 0 and no done_o pulse.
REQ-032 Start with mode 11 -> no state change and all outputs 0; start_i pulsed during RUN at round 3 -> sequence unchanged and no second operation.
REQ-033 reset_i=1 at round 5 of p12 -> IDLE with all outputs 0 at the next edge and no done_o; a start in the cycle after reset release -> full p12 sequence.
REQ-034 Back-to-back: start_i held high continuously with mode 01 -> done_o pulses separated by exactly 8 cycles.
